dmem_arbiter: RTL and testbench

Shares the single-port data blockram between the monocycle CPU data port and a display/debug reader. The reader is a VGA-style word fetcher.
- CPU has priority. The reader is served only on cycles where the CPU makes no data access, unless the optional starvation guard fires.
- Reader requests are queued in a small address FIFO. Read data returns in order, one cycle after each grant.
- Sits in top between franken_riscv's data port and blockram; the reader port feeds the frame fetcher.

---
 rtl/dmem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-port data blockram between the CPU data
//                port (priority) and an in-order display/debug word reader.
//                Reader addresses are queued in a small FIFO; read data comes
//                back one cycle after each reader grant.
//                Optional macro DMEM_ARB_STARVE_GUARD_EN adds a starvation
//                guard that forces one reader grant (stalling the CPU) once a
//                queued request has waited STARVE_LIMIT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int RD_ADDR_W    = 14,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [3:0]           cpu_be,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 rd_req,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic                 rd_ready,
    output logic                 rd_rvalid,
    output logic [31:0]          rd_rdata,
    output logic [31:0]          ram_addr,
    output logic [3:0]           ram_be,
    output logic [31:0]          ram_wdata,
    output logic                 ram_we,
    input  logic [31:0]          ram_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(FIFO_DEPTH);

    // Owner encoding: who holds the blockram port this cycle
    localparam logic [1:0] c_own_none = 2'd0;
    localparam logic [1:0] c_own_cpu  = 2'd1;
    localparam logic [1:0] c_own_rd   = 2'd2;

    // Elaboration-time parameter sanity checks
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dmem_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 2) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be >= 2");
    end
    if (RD_ADDR_W > 30) begin : g_bad_addr_w
        $error("dmem_arbiter: RD_ADDR_W must be <= 30");
    end

    logic [1:0]           r_owner;
    logic [1:0]           w_grant;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [RD_ADDR_W-1:0] r_queue [FIFO_DEPTH];
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_force;
    logic [31:0]          w_rd_byte_addr;
    logic [31:0]          r_hold_addr;
    logic [31:0]          r_hold_wdata;

    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == c_full_count);
    assign rd_ready       = !reset && !w_full;
    assign w_push         = rd_req && rd_ready;
    assign w_pop          = (w_grant == c_own_rd);
    assign w_rd_byte_addr = {30'(r_queue[r_head]), 2'b00};

    assign cpu_rdata = ram_rdata;
    assign rd_rdata  = ram_rdata;
    assign rd_rvalid = (r_owner == c_own_rd);

    // Owner register: remembers last cycle's grant to steer the read data
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_owner <= c_own_none;
        end else begin
            r_owner <= w_grant;
        end
    end

    // Grant decision: forced reader, then CPU, then queued reader, else idle
    always_comb begin
        w_grant = c_own_none;
        if (reset) begin
            w_grant = c_own_none;
        end else if (w_force) begin
            w_grant = c_own_rd;
        end else if (cpu_req) begin
            w_grant = c_own_cpu;
        end else if (!w_empty) begin
            w_grant = c_own_rd;
        end
    end

    // Blockram port mux; idle cycles park address/data at their last value
    always_comb begin
        ram_addr  = r_hold_addr;
        ram_wdata = r_hold_wdata;
        ram_be    = 4'h0;
        ram_we    = 1'b0;
        case (w_grant)
            c_own_cpu: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_be    = cpu_be;
                ram_we    = cpu_we;
            end
            c_own_rd: begin
                ram_addr  = w_rd_byte_addr;
                ram_wdata = 32'h0;
                ram_be    = 4'hF;
                ram_we    = 1'b0;
            end
            default: begin
                ram_be = 4'h0;
            end
        endcase
    end

    // Last driven address/data, replayed on idle cycles to avoid toggling
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_hold_addr  <= 32'h0;
            r_hold_wdata <= 32'h0;
        end else begin
            r_hold_addr  <= ram_addr;
            r_hold_wdata <= ram_wdata;
        end
    end

    // Queue pointers and occupancy; a push and pop together leave count unchanged
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents need no reset since occupancy gates every read
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_queue[r_tail] <= rd_addr;
        end
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [WAIT_W-1:0] c_wait_fire = WAIT_W'(STARVE_LIMIT - 1);

    logic              r_force;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_inc;

    assign w_wait_inc = r_wait_cnt + WAIT_W'(1);
    assign w_force    = r_force;
    assign cpu_stall  = r_force && !reset;

    // Age of the waiting head request; arms a one-cycle forced grant at the limit
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_force    <= 1'b0;
        end else begin
            r_force <= 1'b0;
            if (!w_empty && !w_pop) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == c_wait_fire) begin
                    r_force <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end
`else
    assign w_force   = 1'b0;
    assign cpu_stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a small
//                byte-enabled synchronous-read blockram model. Handles both
//                builds of DMEM_ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        rd_req;
    logic [13:0] rd_addr;
    logic        rd_ready;
    logic        rd_rvalid;
    logic [31:0] rd_rdata;
    logic [31:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(
        .RD_ADDR_W    (14),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (16)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .ram_addr  (ram_addr),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Blockram model: word i preloads 0x5A000000+i while reset is held
    always @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= 32'h5A00_0000 + 32'(i);
            end
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) begin
                    mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
        ram_rdata <= mem[ram_addr[11:2]];
    end

    task automatic tick;
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_be    = 4'h0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        rd_req    = 1'b1;
        rd_addr   = 14'h0005;

        // Reset with reader and a CPU store both requesting
        repeat (3) tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h10;
        settle;
        chk("rst_rd_ready", rd_ready, 32'd0);
        chk("rst_ram_we", ram_we, 32'd0);
        chk("rst_ram_be", ram_be, 32'd0);
        chk("rst_rvalid", rd_rvalid, 32'd0);
        chk("rst_stall", cpu_stall, 32'd0);
        tick;
        reset = 1'b0; rd_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
        tick;
        settle;
        chk("post_rst_ready", rd_ready, 32'd1);
        chk("post_rst_empty_be", ram_be, 32'd0);
        chk("post_rst_rvalid", rd_rvalid, 32'd0);

        // Single reader fetch with idle CPU
        tick;
        rd_req = 1'b1; rd_addr = 14'h0010;
        settle;
        chk("push_ready", rd_ready, 32'd1);
        chk("push_no_same_cycle_grant", ram_be, 32'd0);
        tick;
        rd_req = 1'b0;
        settle;
        chk("rd_grant_addr", ram_addr, 32'h0000_0040);
        chk("rd_grant_be", ram_be, 32'hF);
        chk("rd_grant_we", ram_we, 32'd0);
        chk("rd_grant_rvalid", rd_rvalid, 32'd0);
        tick;
        settle;
        chk("rd_rvalid", rd_rvalid, 32'd1);
        chk("rd_rdata", rd_rdata, 32'h5A00_0010);
        chk("idle_be", ram_be, 32'd0);
        chk("idle_addr_hold", ram_addr, 32'h0000_0040);

        // CPU busy for 10 cycles while three reader requests queue up
        for (int i = 0; i < 10; i++) begin
            tick;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF;
            cpu_addr = 32'h200 + 32'(4 * i);
            rd_req = (i < 3);
            rd_addr = 14'(32'h20 + i);
            settle;
            chk("busy_addr", ram_addr, 32'h200 + 32'(4 * i));
            chk("busy_be", ram_be, 32'hF);
            chk("busy_rvalid", rd_rvalid, 32'd0);
            if (i < 3) chk("busy_push_ready", rd_ready, 32'd1);
        end
        tick;
        cpu_req = 1'b0; rd_req = 1'b0;
        settle;
        chk("drain0_addr", ram_addr, 32'h0000_0080);
        chk("drain0_rvalid", rd_rvalid, 32'd0);
        tick;
        settle;
        chk("drain1_rvalid", rd_rvalid, 32'd1);
        chk("drain1_rdata", rd_rdata, 32'h5A00_0020);
        chk("drain1_addr", ram_addr, 32'h0000_0084);
        tick;
        settle;
        chk("drain2_rvalid", rd_rvalid, 32'd1);
        chk("drain2_rdata", rd_rdata, 32'h5A00_0021);
        chk("drain2_addr", ram_addr, 32'h0000_0088);
        tick;
        settle;
        chk("drain3_rvalid", rd_rvalid, 32'd1);
        chk("drain3_rdata", rd_rdata, 32'h5A00_0022);
        chk("drain3_be", ram_be, 32'd0);

        // Fill the queue under constant CPU traffic, hold the 5th request
        for (int i = 0; i < 4; i++) begin
            tick;
            cpu_req = 1'b1; cpu_addr = 32'h204;
            rd_req = 1'b1; rd_addr = 14'(32'h30 + i);
            settle;
            chk("fill_ready", rd_ready, 32'd1);
        end
        tick;
        rd_addr = 14'h0034;
        settle;
        chk("full_ready", rd_ready, 32'd0);
        chk("full_cpu_addr", ram_addr, 32'h0000_0204);
        tick;
        settle;
        chk("full_ready_held", rd_ready, 32'd0);
        tick;
        cpu_req = 1'b0;
        settle;
        chk("full_pop_ready", rd_ready, 32'd0);
        chk("full_pop_addr", ram_addr, 32'h0000_00C0);
        tick;
        settle;
        chk("after_pop_ready", rd_ready, 32'd1);
        chk("after_pop_rdata", rd_rdata, 32'h5A00_0030);
        chk("after_pop_addr", ram_addr, 32'h0000_00C4);
        tick;
        rd_req = 1'b0;
        settle;
        chk("full_d1_rdata", rd_rdata, 32'h5A00_0031);
        tick;
        settle;
        chk("full_d2_rdata", rd_rdata, 32'h5A00_0032);
        tick;
        settle;
        chk("full_d3_rdata", rd_rdata, 32'h5A00_0033);
        chk("full_d3_addr", ram_addr, 32'h0000_00D0);
        tick;
        settle;
        chk("full_d4_rvalid", rd_rvalid, 32'd1);
        chk("full_d4_rdata", rd_rdata, 32'h5A00_0034);
        chk("full_d4_be", ram_be, 32'd0);

        // CPU store wins over a queued reader request
        tick;
        rd_req = 1'b1; rd_addr = 14'h0040;
        settle;
        tick;
        rd_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_be = 4'b0011; cpu_wdata = 32'hAABB_CCDD;
        settle;
        chk("st_we", ram_we, 32'd1);
        chk("st_addr", ram_addr, 32'h0000_0100);
        chk("st_be", ram_be, 32'h3);
        chk("st_wdata", ram_wdata, 32'hAABB_CCDD);
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
        settle;
        chk("st_then_rd_addr", ram_addr, 32'h0000_0100);
        chk("st_then_rd_rvalid", rd_rvalid, 32'd0);
        tick;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_be = 4'hF;
        settle;
        chk("st_rd_rvalid", rd_rvalid, 32'd1);
        chk("st_rd_rdata", rd_rdata, 32'h5A00_CCDD);
        chk("ld_we", ram_we, 32'd0);
        tick;
        cpu_req = 1'b0; cpu_be = 4'h0;
        settle;
        chk("ld_rdata", cpu_rdata, 32'h5A00_CCDD);

        // Reader starvation under continuous CPU stores
        tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h300; cpu_wdata = 32'h1234_5678;
        rd_req = 1'b1; rd_addr = 14'h0050;
        settle;
        chk("sv_push_ready", rd_ready, 32'd1);
        for (int k = 1; k <= 18; k++) begin
            tick;
            rd_req = 1'b0;
            settle;
`ifdef DMEM_ARB_STARVE_GUARD_EN
            if (k == 16) begin
                chk("sv_stall", cpu_stall, 32'd1);
                chk("sv_force_we", ram_we, 32'd0);
                chk("sv_force_addr", ram_addr, 32'h0000_0140);
            end else begin
                chk("sv_no_stall", cpu_stall, 32'd0);
            end
            if (k == 17) begin
                chk("sv_rvalid", rd_rvalid, 32'd1);
                chk("sv_rdata", rd_rdata, 32'h5A00_0050);
            end else begin
                chk("sv_no_rvalid", rd_rvalid, 32'd0);
            end
`else
            chk("ns_no_stall", cpu_stall, 32'd0);
            chk("ns_no_rvalid", rd_rvalid, 32'd0);
            chk("ns_cpu_we", ram_we, 32'd1);
`endif
        end
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
        settle;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        chk("sv_end_idle_be", ram_be, 32'd0);
`else
        chk("ns_late_grant_addr", ram_addr, 32'h0000_0140);
        tick;
        settle;
        chk("ns_late_rvalid", rd_rvalid, 32'd1);
        chk("ns_late_rdata", rd_rdata, 32'h5A00_0050);
`endif
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
